// File: rtl/fire_pkg.sv
// Shared types and helpers for the fire-module bias/ReLU output stage.
package fire_pkg;

    localparam int          BIAS_W  = 16;
    localparam logic [15:0] SAT_MAX = 16'h7FFF;

    // Bias word as stored in the per-layer ROM: sign bit plus 15-bit magnitude.
    typedef struct packed {
        logic        sign;
        logic [14:0] mag;
    } bias_sm_t;

    // Sign-magnitude to 17-bit two's complement; negative zero maps to 0.
    function automatic logic signed [BIAS_W:0] sm_to_tc(input bias_sm_t b);
        logic signed [BIAS_W:0] mag_v;
        mag_v = $signed({2'b00, b.mag});
        if (b.sign) begin
            sm_to_tc = -mag_v;
        end else begin
            sm_to_tc = mag_v;
        end
    endfunction

endpackage

// File: rtl/bias_sat_relu.sv
// Saturates a biased accumulator sum to +/-32767, applies optional ReLU and
// encodes the result as 16-bit sign-magnitude (zero is always 16'h0000).
module bias_sat_relu
    import fire_pkg::*;
#(
    parameter int ACC_W   = 24,
    parameter bit RELU_EN = 1'b1
) (
    input  logic signed [ACC_W:0]    sum,
    output logic        [BIAS_W-1:0] result
);

    localparam logic signed [ACC_W:0] POS_LIM =
        $signed({{(ACC_W + 1 - BIAS_W){1'b0}}, SAT_MAX});
    localparam logic signed [ACC_W:0] NEG_LIM = -POS_LIM;

    logic        sign_s;
    logic [14:0] mag_s;

    // Clamp and split the sum into sign and magnitude, then apply ReLU.
    always_comb begin
        sign_s = 1'b0;
        mag_s  = 15'h0000;
        result = 16'h0000;
        if (sum > POS_LIM) begin
            sign_s = 1'b0;
            mag_s  = 15'h7FFF;
        end else if (sum < NEG_LIM) begin
            sign_s = 1'b1;
            mag_s  = 15'h7FFF;
        end else if (sum[ACC_W]) begin
            // Strictly negative here, so the magnitude is never zero.
            sign_s = 1'b1;
            mag_s  = 15'(-sum);
        end else begin
            sign_s = 1'b0;
            mag_s  = 15'(sum);
        end
        if (RELU_EN && sign_s) begin
            result = 16'h0000;
        end else begin
            result = {sign_s, mag_s};
        end
    end

endmodule

// File: rtl/fire_bias_relu.sv
// Bias-add, saturate and ReLU stage between a fire-module MAC array and its
// output buffer. Tracks the output channel implicitly from beat order and
// reads the matching bias from the static ROM bus. Two-stage valid/ready pipe.
module fire_bias_relu
    import fire_pkg::*;
#(
    parameter int NUM_CH  = 64,
    parameter int ACC_W   = 24,
    parameter bit RELU_EN = 1'b1,
    parameter int CH_W    = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [BIAS_W-1:0] bias_mem [NUM_CH],
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ACC_W-1:0]  in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BIAS_W-1:0] out_data,
    output logic [CH_W-1:0]   out_ch,
    output logic              out_last
);

    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

    logic [CH_W-1:0]         ch_cnt_r;
    logic                    en1_s;
    logic                    en2_s;
    logic                    accept_s;
    bias_sm_t                bias_sm_s;
    logic signed [BIAS_W:0]  bias_tc_s;
    logic signed [ACC_W:0]   bias_ext_s;
    logic signed [ACC_W:0]   sum_s;

    logic                    s1_valid_r;
    logic signed [ACC_W:0]   s1_sum_r;
    logic [CH_W-1:0]         s1_ch_r;
    logic                    s1_last_r;
    logic [BIAS_W-1:0]       sat_res_s;

    // Handshake: a stage may load when it is empty or its consumer advances.
    always_comb begin
        en2_s    = !out_valid || out_ready;
        en1_s    = !s1_valid_r || en2_s;
        in_ready = en1_s && !clear;
        accept_s = in_valid && in_ready;
    end

    // Bias lookup by current channel and full-precision add (cannot overflow).
    always_comb begin
        bias_sm_s  = bias_sm_t'(bias_mem[ch_cnt_r]);
        bias_tc_s  = sm_to_tc(bias_sm_s);
        bias_ext_s = {{(ACC_W - BIAS_W){bias_tc_s[BIAS_W]}}, bias_tc_s};
        sum_s      = $signed({in_data[ACC_W-1], in_data}) + bias_ext_s;
    end

    // Channel counter: advances per accepted beat, wraps at the last channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_cnt_r <= '0;
        end else if (clear) begin
            ch_cnt_r <= '0;
        end else if (accept_s) begin
            if (ch_cnt_r == LAST_CH) begin
                ch_cnt_r <= '0;
            end else begin
                ch_cnt_r <= ch_cnt_r + CH_W'(1);
            end
        end
    end

    // Stage 1: capture the biased sum with its channel and last flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s1_sum_r   <= '0;
            s1_ch_r    <= '0;
            s1_last_r  <= 1'b0;
        end else if (clear) begin
            s1_valid_r <= 1'b0;
        end else if (en1_s) begin
            s1_valid_r <= in_valid;
            s1_sum_r   <= sum_s;
            s1_ch_r    <= ch_cnt_r;
            s1_last_r  <= (ch_cnt_r == LAST_CH);
        end
    end

    bias_sat_relu #(
        .ACC_W   (ACC_W),
        .RELU_EN (RELU_EN)
    ) u_bias_sat_relu (
        .sum    (s1_sum_r),
        .result (sat_res_s)
    );

    // Stage 2: registered outputs; hold while downstream stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= 16'h0000;
            out_ch    <= '0;
            out_last  <= 1'b0;
        end else if (clear) begin
            out_valid <= 1'b0;
        end else if (en2_s) begin
            out_valid <= s1_valid_r;
            out_data  <= sat_res_s;
            out_ch    <= s1_ch_r;
            out_last  <= s1_last_r;
        end
    end

endmodule

// File: tb/tb_fire_bias_relu.sv
// Directed self-checking bench for fire_bias_relu. Two instances share the
// input stream: one with ReLU enabled, one without.
module tb_fire_bias_relu;

    logic        clk;
    logic        rst_n;
    logic        clear;
    logic        in_valid;
    logic [23:0] in_data;
    logic        out_ready;
    logic [15:0] bias_mem [64];

    logic        r1_in_ready, r1_out_valid, r1_out_last;
    logic [15:0] r1_out_data;
    logic [5:0]  r1_out_ch;
    logic        r0_in_ready, r0_out_valid, r0_out_last;
    logic [15:0] r0_out_data;
    logic [5:0]  r0_out_ch;

    int checks;
    int failures;

    fire_bias_relu #(.NUM_CH(64), .ACC_W(24), .RELU_EN(1'b1)) dut_relu (
        .clk       (clk),
        .rst_n     (rst_n),
        .bias_mem  (bias_mem),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (r1_in_ready),
        .in_data   (in_data),
        .out_valid (r1_out_valid),
        .out_ready (out_ready),
        .out_data  (r1_out_data),
        .out_ch    (r1_out_ch),
        .out_last  (r1_out_last)
    );

    fire_bias_relu #(.NUM_CH(64), .ACC_W(24), .RELU_EN(1'b0)) dut_lin (
        .clk       (clk),
        .rst_n     (rst_n),
        .bias_mem  (bias_mem),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (r0_in_ready),
        .in_data   (in_data),
        .out_valid (r0_out_valid),
        .out_ready (out_ready),
        .out_data  (r0_out_data),
        .out_ch    (r0_out_ch),
        .out_last  (r0_out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One beat on channel 0 after a clear; checks both ReLU variants.
    task automatic single(input string tag, input logic [23:0] d,
                          input logic [15:0] exp_relu, input logic [15:0] exp_lin);
        clear = 1'b1; in_valid = 1'b0;
        tick;
        clear = 1'b0; in_valid = 1'b1; in_data = d;
        tick;
        in_valid = 1'b0;
        tick;
        chk({tag, "_valid"},    32'(r1_out_valid), 32'h1);
        chk({tag, "_ch"},       32'(r1_out_ch),    32'h0);
        chk({tag, "_relu"},     32'(r1_out_data),  32'(exp_relu));
        chk({tag, "_lin"},      32'(r0_out_data),  32'(exp_lin));
    endtask

    initial begin
        checks = 0; failures = 0;
        for (int i = 0; i < 64; i++) bias_mem[i] = 16'h0000;
        bias_mem[0] = 16'h00C1;   // +193
        bias_mem[1] = 16'h8001;   // -1
        bias_mem[2] = 16'h8000;   // negative zero
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = 24'h0; out_ready = 1'b1;

        // Reset state
        #12;
        chk("rst_valid", 32'(r1_out_valid), 32'h0);
        chk("rst_data",  32'(r1_out_data),  32'h0);
        chk("rst_ch",    32'(r1_out_ch),    32'h0);
        chk("rst_last",  32'(r1_out_last),  32'h0);
        tick;
        rst_n = 1'b1;
        tick;
        chk("rst_in_ready", 32'(r1_in_ready), 32'h1);

        // Basic stream: 100+193, 100-1, 5-0
        in_valid = 1'b1; in_data = 24'd100;
        tick;
        chk("s1_not_yet", 32'(r1_out_valid), 32'h0);
        in_data = 24'd100;
        tick;
        chk("st0_valid", 32'(r1_out_valid), 32'h1);
        chk("st0_data",  32'(r1_out_data),  32'h0125);
        chk("st0_ch",    32'(r1_out_ch),    32'h0);
        in_data = 24'd5;
        tick;
        in_valid = 1'b0;
        chk("st1_data",  32'(r1_out_data),  32'h0063);
        chk("st1_ch",    32'(r1_out_ch),    32'h1);
        tick;
        chk("st2_data",  32'(r1_out_data),  32'h0005);
        chk("st2_ch",    32'(r1_out_ch),    32'h2);
        chk("st2_last",  32'(r1_out_last),  32'h0);
        tick;
        chk("st_drain",  32'(r1_out_valid), 32'h0);

        // Negative result, saturation both directions
        single("neg1000", 24'hFFFC18, 16'h0000, 16'h8327);
        single("satpos",  24'h7FFFFF, 16'h7FFF, 16'h7FFF);
        single("satneg",  24'h800000, 16'h0000, 16'hFFFF);

        // 130 zero beats: channel wraps, last on beats 63 and 127
        clear = 1'b1;
        tick;
        clear = 1'b0; in_data = 24'h0;
        for (int i = 0; i <= 130; i++) begin
            in_valid = (i < 130);
            tick;
            if (i >= 1) begin
                chk("wrap_valid", 32'(r1_out_valid), 32'h1);
                chk("wrap_ch",    32'(r1_out_ch),    32'((i - 1) % 64));
                chk("wrap_last",  32'(r1_out_last),  (((i - 1) % 64) == 63) ? 32'h1 : 32'h0);
            end
        end
        in_valid = 1'b0;
        tick;

        // Stall: only two beats buffered, outputs hold, order kept on release
        clear = 1'b1;
        tick;
        clear = 1'b0; out_ready = 1'b0; in_valid = 1'b1; in_data = 24'd10;
        tick;
        in_data = 24'd20;
        tick;
        in_data = 24'd30;
        chk("stall_in_ready", 32'(r1_in_ready), 32'h0);
        chk("stall_data0",    32'(r1_out_data), 32'h00CB);
        chk("stall_ch0",      32'(r1_out_ch),   32'h0);
        tick;
        tick;
        chk("stall_hold_valid", 32'(r1_out_valid), 32'h1);
        chk("stall_hold_data",  32'(r1_out_data),  32'h00CB);
        chk("stall_hold_ch",    32'(r1_out_ch),    32'h0);
        chk("stall_hold_rdy",   32'(r1_in_ready),  32'h0);
        out_ready = 1'b1;
        #1;
        chk("release_rdy", 32'(r1_in_ready), 32'h1);
        tick;
        chk("rel_data1", 32'(r1_out_data), 32'h0013);
        chk("rel_ch1",   32'(r1_out_ch),   32'h1);
        in_data = 24'd40;
        tick;
        in_valid = 1'b0;
        chk("rel_data2", 32'(r1_out_data), 32'h001E);
        chk("rel_ch2",   32'(r1_out_ch),   32'h2);
        tick;
        chk("rel_data3", 32'(r1_out_data), 32'h0028);
        chk("rel_ch3",   32'(r1_out_ch),   32'h3);
        tick;
        chk("rel_empty", 32'(r1_out_valid), 32'h0);

        // Clear after 10 beats mid-stream
        in_valid = 1'b1; in_data = 24'h0;
        for (int i = 0; i < 10; i++) tick;
        clear = 1'b1;
        #1;
        chk("clr_in_ready", 32'(r1_in_ready), 32'h0);
        tick;
        chk("clr_valid", 32'(r1_out_valid), 32'h0);
        clear = 1'b0; in_data = 24'd7;
        tick;
        in_valid = 1'b0;
        tick;
        chk("clr_next_data", 32'(r1_out_data), 32'h00C8);
        chk("clr_next_ch",   32'(r1_out_ch),   32'h0);

        // Reset mid-stream
        in_valid = 1'b1; in_data = 24'h0;
        for (int i = 0; i < 5; i++) tick;
        rst_n = 1'b0;
        #1;
        chk("mrst_valid", 32'(r1_out_valid), 32'h0);
        tick;
        rst_n = 1'b1; in_data = 24'd7;
        tick;
        in_valid = 1'b0;
        tick;
        chk("mrst_next_valid", 32'(r1_out_valid), 32'h1);
        chk("mrst_next_data",  32'(r1_out_data),  32'h00C8);
        chk("mrst_next_ch",    32'(r1_out_ch),    32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
